// File: rtl/nes_pal_pkg.sv
// Shared palette-load types: RGB entry layout, controller states and palette geometry.
// Entry bytes arrive R, G, B; a full .pal holds PAL_ENTRIES * PAL_BYTES_PER_ENTRY bytes.
package nes_pal_pkg;
   localparam int PAL_ENTRIES         = 64;
   localparam int PAL_BYTES_PER_ENTRY = 3;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb24_t;

   typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} pal_load_state_t;
endpackage

// File: rtl/pal_load_ctrl_if.sv
// Host download stream plus palette RAM write port; master is the host/video side,
// slave is the load controller.
interface pal_load_ctrl_if
   import nes_pal_pkg::*;
#(
   parameter int IDX_W = 6
);
   logic             dl_en;
   logic             dl_wr;
   logic [7:0]       dl_data;
   logic             blank;
   logic             dl_wait;
   logic             load_color;
   rgb24_t           load_color_data;
   logic [IDX_W-1:0] load_color_index;

   modport master (
      output dl_en, dl_wr, dl_data, blank,
      input  dl_wait, load_color, load_color_data, load_color_index
   );

   modport slave (
      input  dl_en, dl_wr, dl_data, blank,
      output dl_wait, load_color, load_color_data, load_color_index
   );
endinterface

// File: rtl/pal_byte_packer.sv
// Assembles R,G,B download bytes into one entry; entry_done fires combinationally on the
// completing byte with rgb valid in the same cycle. No backpressure of its own.
module pal_byte_packer
   import nes_pal_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       byte_vld,
   input  logic [7:0] byte_dat,
   output logic [1:0] byte_cnt,
   output rgb24_t     rgb,
   output logic       entry_done
);
   localparam logic [1:0] LAST = 2'(PAL_BYTES_PER_ENTRY - 1);

   logic [1:0] cnt_q, cnt_d;
   logic [7:0] r_q, r_d;
   logic [7:0] g_q, g_d;

   always_comb begin
      cnt_d = cnt_q;
      r_d   = r_q;
      g_d   = g_q;
      if (clr) begin
         cnt_d = 2'd0;
      end else if (byte_vld) begin
         cnt_d = (cnt_q == LAST) ? 2'd0 : cnt_q + 2'd1;
         if (cnt_q == 2'd0) r_d = byte_dat;
         if (cnt_q == 2'd1) g_d = byte_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 2'd0;
         r_q   <= 8'd0;
         g_q   <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
         r_q   <= r_d;
         g_q   <= g_d;
      end
   end

   assign byte_cnt   = cnt_q;
   assign entry_done = byte_vld & (cnt_q == LAST);
   assign rgb        = {r_q, g_q, byte_dat};
endmodule

// File: rtl/pal_load_ctrl.sv
// Loads a 64-entry RGB palette from a host byte stream into palette RAM; commits one cycle after
// capture, inside blanking when PAL_LOAD_BLANK_GATE_EN is defined. Host stalled via dl_wait.
module pal_load_ctrl
   import nes_pal_pkg::*;
#(
   parameter int ENTRIES = PAL_ENTRIES,
   parameter int IDX_W   = $clog2(ENTRIES)
)(
   input  logic            clk,
   input  logic            reset,
   pal_load_ctrl_if.slave  bus,
   output logic            palette_valid,
   output logic            load_error,
   output logic            busy
);
   localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(ENTRIES);

   pal_load_state_t state_q, state_d;
   logic            dl_en_q, dl_en_d;
   logic            rise_lat_q, rise_lat_d;
   logic            pend_q, pend_d;
   rgb24_t          hold_q, hold_d;
   logic [IDX_W:0]  entry_idx_q, entry_idx_d;
   logic [IDX_W:0]  cap_cnt_q, cap_cnt_d;
   logic            err_q, err_d;
   logic            palette_valid_q, palette_valid_d;
   logic            load_error_q, load_error_d;
   logic            busy_q, busy_d;

   logic            win, rise, fall, in_recv, commit, byte_acc, byte_drop;
   logic            start, partial;
   logic [1:0]      byte_cnt;
   rgb24_t          pk_rgb;
   logic            entry_done;

`ifdef PAL_LOAD_BLANK_GATE_EN
   assign win = bus.blank;
`else
   // Writes go out immediately; a stolen pixel read shows as a one-pixel glitch.
   logic blank_unused;
   assign blank_unused = bus.blank;
   assign win = 1'b1;
`endif

   assign rise      = bus.dl_en & ~dl_en_q;
   assign fall      = ~bus.dl_en & dl_en_q;
   assign in_recv   = (state_q == RECV);
   assign commit    = pend_q & win;
   assign byte_drop = in_recv & bus.dl_wr & bus.dl_wait;
   // Once every entry is captured, surplus bytes (emphasis files) are swallowed silently.
   assign byte_acc  = in_recv & bus.dl_wr & ~bus.dl_wait & (cap_cnt_q != FULL_CNT);

   pal_byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clr        (start),
      .byte_vld   (byte_acc),
      .byte_dat   (bus.dl_data),
      .byte_cnt   (byte_cnt),
      .rgb        (pk_rgb),
      .entry_done (entry_done)
   );

   always_comb begin
      state_d         = state_q;
      dl_en_d         = bus.dl_en;
      rise_lat_d      = rise_lat_q;
      pend_d          = pend_q;
      hold_d          = hold_q;
      entry_idx_d     = entry_idx_q;
      cap_cnt_d       = cap_cnt_q;
      err_d           = err_q;
      palette_valid_d = palette_valid_q;
      load_error_d    = load_error_q;
      start           = 1'b0;
      partial         = byte_acc ? (byte_cnt != 2'd2) : (byte_cnt != 2'd0);

      if (commit) begin
         entry_idx_d = entry_idx_q + 1'b1;
         pend_d      = 1'b0;
      end
      if (entry_done) begin
         hold_d    = pk_rgb;
         pend_d    = 1'b1;
         cap_cnt_d = cap_cnt_q + 1'b1;
      end
      if (byte_drop) err_d = 1'b1;

      case (state_q)
         IDLE:  if (rise) start = 1'b1;
         RECV:  if (fall) begin
                   state_d = DRAIN;
                   if (partial) err_d = 1'b1;
                end
         DRAIN: begin
                   if (rise) rise_lat_d = 1'b1;
                   if (!pend_q) state_d = DONE;
                end
         DONE:  begin
                   palette_valid_d = (entry_idx_q == FULL_CNT) & ~err_q;
                   load_error_d    = ~palette_valid_d;
                   state_d         = IDLE;
                   if (rise | rise_lat_q) start = 1'b1;
                end
         default: state_d = IDLE;
      endcase

      if (start) begin
         state_d         = RECV;
         rise_lat_d      = 1'b0;
         pend_d          = 1'b0;
         entry_idx_d     = '0;
         cap_cnt_d       = '0;
         err_d           = 1'b0;
         palette_valid_d = 1'b0;
         load_error_d    = 1'b0;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         dl_en_q         <= 1'b0;
         rise_lat_q      <= 1'b0;
         pend_q          <= 1'b0;
         hold_q          <= '0;
         entry_idx_q     <= '0;
         cap_cnt_q       <= '0;
         err_q           <= 1'b0;
         palette_valid_q <= 1'b0;
         load_error_q    <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         dl_en_q         <= dl_en_d;
         rise_lat_q      <= rise_lat_d;
         pend_q          <= pend_d;
         hold_q          <= hold_d;
         entry_idx_q     <= entry_idx_d;
         cap_cnt_q       <= cap_cnt_d;
         err_q           <= err_d;
         palette_valid_q <= palette_valid_d;
         load_error_q    <= load_error_d;
         busy_q          <= busy_d;
      end
   end

   assign bus.dl_wait          = pend_q & (byte_cnt == 2'd2);
   assign bus.load_color       = commit;
   assign bus.load_color_data  = hold_q;
   assign bus.load_color_index = entry_idx_q[IDX_W-1:0];
   assign palette_valid        = palette_valid_q;
   assign load_error           = load_error_q;
   assign busy                 = busy_q;
endmodule

// File: tb/tb_pal_load_ctrl.sv
// Directed bench for pal_load_ctrl: table of whole-file loads plus hand sequences for
// re-rise during drain and (with PAL_LOAD_BLANK_GATE_EN) blank-gated commits and overrun.
module tb_pal_load_ctrl;
   import nes_pal_pkg::*;

   localparam int IDX_W = 6;

   logic clk = 1'b0;
   logic reset;
   logic palette_valid, load_error, busy;

   pal_load_ctrl_if #(.IDX_W(IDX_W)) bus ();

   pal_load_ctrl #(.ENTRIES(64), .IDX_W(IDX_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .palette_valid (palette_valid),
      .load_error    (load_error),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0]  idx;
      logic [23:0] data;
   } exp_t;

   typedef struct {
      int n;
      int rst_at;
      bit fall_last;
      int exp_strobes;
      bit exp_valid;
      bit exp_err;
   } row_t;

   int   total = 0;
   int   bad   = 0;
   int   strobes;
   bit   saw_wait;
   exp_t expq[$];
   exp_t mon_e;
   row_t rows[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_wr(input logic [7:0] b, input bit fall_too);
      bus.dl_wr   = 1'b1;
      bus.dl_data = b;
      if (fall_too) bus.dl_en = 1'b0;
      tick();
      bus.dl_wr = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit fall_too);
      int n = 0;
      while (bus.dl_wait && n < 2000) begin
         tick();
         n++;
      end
      if (bus.dl_wait) check("dl_wait_timeout", 32'(bus.dl_wait), 32'd0);
      pulse_wr(b, fall_too);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      check("busy_end", 32'(busy), 32'd0);
   endtask

   function automatic exp_t pat_entry(input int k);
      pat_entry.idx  = 6'(k);
      pat_entry.data = {8'(k), 8'(k + 1), 8'(k + 2)};
   endfunction

   // Checks every RAM write strobe against the next expected {index, data}.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.dl_wait) saw_wait = 1'b1;
         if (bus.load_color) begin
            strobes++;
            if (expq.size() == 0) begin
               check("unexpected_strobe", {2'b0, bus.load_color_index, bus.load_color_data}, 32'd0);
            end else begin
               mon_e = expq.pop_front();
               check("strobe", {2'b0, bus.load_color_index, bus.load_color_data}, {2'b0, mon_e});
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      logic [7:0] b;
      int         nsend;

      rows[0] = '{192,  0,   0, 64, 1, 0};
      rows[1] = '{150,  0,   0, 50, 0, 1};
      rows[2] = '{1536, 0,   0, 64, 1, 0};
      rows[3] = '{190,  0,   0, 63, 0, 1};
      rows[4] = '{193,  0,   0, 64, 1, 0};
      rows[5] = '{192,  100, 0, 33, 0, 0};
      rows[6] = '{192,  0,   1, 64, 1, 0};
      rows[7] = '{0,    0,   0, 0,  0, 1};
      rows[8] = '{4,    0,   0, 1,  0, 1};

      reset       = 1'b1;
      bus.dl_en   = 1'b0;
      bus.dl_wr   = 1'b0;
      bus.dl_data = 8'd0;
      bus.blank   = 1'b1;
      strobes     = 0;
      saw_wait    = 1'b0;
      repeat (3) tick();
      reset = 1'b0;

      check("rst_palette_valid", 32'(palette_valid), 32'd0);
      check("rst_load_error", 32'(load_error), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_load_color", 32'(bus.load_color), 32'd0);
      check("rst_dl_wait", 32'(bus.dl_wait), 32'd0);
      check("rst_idx_data", {2'b0, bus.load_color_index, bus.load_color_data}, 32'd0);

      for (int r = 0; r < 9; r++) begin
         expq.delete();
         strobes  = 0;
         saw_wait = 1'b0;
         repeat (3) tick();
         bus.dl_en = 1'b1;
         tick();
         tick();
         nsend = (rows[r].rst_at != 0) ? rows[r].rst_at : rows[r].n;
         for (int j = 0; j < nsend; j++) begin
            b = 8'(j / 3 + j % 3);
            send_byte(b, rows[r].fall_last && (j == rows[r].n - 1));
            if ((j % 3) == 2 && (j / 3) < 64) expq.push_back(pat_entry(j / 3));
         end
         if (rows[r].rst_at != 0) begin
            reset     = 1'b1;
            bus.dl_en = 1'b0;
            tick();
            tick();
            reset = 1'b0;
            check("midrst_outputs",
                  {bus.dl_wait, bus.load_color, bus.load_color_index, bus.load_color_data},
                  32'd0);
            check("midrst_busy", 32'(busy), 32'd0);
            repeat (10) tick();
         end else begin
            bus.dl_en = 1'b0;
            wait_idle();
         end
         check($sformatf("row%0d_strobes", r), 32'(strobes), 32'(rows[r].exp_strobes));
         check($sformatf("row%0d_palette_valid", r), 32'(palette_valid), 32'(rows[r].exp_valid));
         check($sformatf("row%0d_load_error", r), 32'(load_error), 32'(rows[r].exp_err));
         check($sformatf("row%0d_dl_wait_seen", r), 32'(saw_wait), 32'd0);
      end

      // dl_en re-rises while the final entry is still draining: second load must follow.
      expq.delete();
      strobes = 0;
      repeat (3) tick();
      bus.dl_en = 1'b1;
      tick();
      tick();
      for (int j = 0; j < 192; j++) begin
         b = 8'(j / 3 + j % 3);
         send_byte(b, j == 191);
         if ((j % 3) == 2) expq.push_back(pat_entry(j / 3));
      end
      bus.dl_en = 1'b1;
      tick();
      check("rerise_busy", 32'(busy), 32'd1);
      repeat (4) tick();
      check("rerise_valid_cleared", 32'(palette_valid), 32'd0);
      for (int j = 0; j < 192; j++) begin
         b = 8'(j / 3 + j % 3);
         send_byte(b, 1'b0);
         if ((j % 3) == 2) expq.push_back(pat_entry(j / 3));
      end
      bus.dl_en = 1'b0;
      wait_idle();
      check("rerise_strobes", 32'(strobes), 32'd128);
      check("rerise_palette_valid", 32'(palette_valid), 32'd1);
      check("rerise_load_error", 32'(load_error), 32'd0);

`ifdef PAL_LOAD_BLANK_GATE_EN
      // Commits held until blank; the completing byte of the next entry stalls and overruns.
      expq.delete();
      strobes   = 0;
      bus.blank = 1'b0;
      repeat (3) tick();
      bus.dl_en = 1'b1;
      tick();
      tick();
      send_byte(8'hFF, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h80, 1'b0);
      expq.push_back('{idx: 6'd0, data: 24'hFF0080});
      repeat (3) tick();
      check("gate_no_strobe", 32'(strobes), 32'd0);
      check("gate_wait_low", 32'(bus.dl_wait), 32'd0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      check("gate_wait_high", 32'(bus.dl_wait), 32'd1);
      pulse_wr(8'h33, 1'b0);
      check("gate_held_strobe", 32'(strobes), 32'd0);
      bus.blank = 1'b1;
      tick();
      check("gate_one_strobe", 32'(strobes), 32'd1);
      check("gate_wait_release", 32'(bus.dl_wait), 32'd0);
      send_byte(8'h44, 1'b0);
      expq.push_back('{idx: 6'd1, data: 24'h112244});
      for (int k = 2; k < 64; k++) begin
         for (int p = 0; p < 3; p++) send_byte(8'(k + p), 1'b0);
         expq.push_back(pat_entry(k));
      end
      bus.dl_en = 1'b0;
      wait_idle();
      check("gate_strobes", 32'(strobes), 32'd64);
      check("gate_overrun_valid", 32'(palette_valid), 32'd0);
      check("gate_overrun_error", 32'(load_error), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pal_load_ctrl.md
Name: pal_load_ctrl

Overview:
- Controller that loads a custom 64-entry RGB palette into the video block's palette RAM from a host byte stream (192-byte .pal download).
- Drives the RAM write interface: load_color, load_color_data, load_color_index.
- The palette RAM is single-ported, and a write steals the pixel read address. Writes are therefore sequenced into blanking and held back otherwise; the host is throttled.
- Reports palette completeness so top level can fall back from palette 5 when the load is short.

Parameters:
- ENTRIES, 64, palette entries written per load.
- IDX_W, 6, width of the entry index (clog2 ENTRIES).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- dl_en  input  1  palette download active (level)
- dl_wr  input  1  one-cycle byte strobe
- dl_data  input  8  download byte
- blank  input  1  HBlank|VBlank from video (safe write window)
- dl_wait  output  1  host must not strobe dl_wr while high
- load_color  output  1  one-cycle RAM write strobe
- load_color_data  output  24  {R,G,B}
- load_color_index  output  IDX_W  entry address
- palette_valid  output  1  full palette loaded
- load_error  output  1  last load short or overrun (sticky)
- busy  output  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, hold register empty.
- States: IDLE, RECV, DRAIN, DONE.
  - IDLE/DONE→RECV on dl_en rising edge (registered edge detect). On entry: clear byte_cnt, entry_idx, pend, palette_valid, load_error.
  - RECV→DRAIN on dl_en falling edge.
  - DRAIN→DONE once pend==0.
  - DONE→IDLE after one cycle.
- Byte assembly (RECV only):
  - Byte order R,G,B. byte_cnt counts 0..2.
  - The third byte copies {R,G,B} into hold_reg and sets pend=1. byte_cnt wraps to 0.
  - Bytes after entry ENTRIES-1 has been captured are ignored. No error; 1536-byte emphasis files are accepted and only the first 64 entries are used.
- dl_wait = pend & (byte_cnt==2). The next entry may assemble while one is pending; only its completing byte stalls.
- A dl_wr while dl_wait is high is dropped and sets load_error.
- Commit: when pend & write window, for 1 cycle:
  - load_color=1.
  - load_color_data=hold_reg.
  - load_color_index=entry_idx.
  - Next cycle: entry_idx+1 and pend=0, unless a new entry completes in that same cycle, in which case pend stays 1 with the new data.
  - Commit latency ≥1 cycle after capture. Back-to-back commits are allowed.
- Completion on DONE:
  - palette_valid=1 iff ENTRIES entries committed and no overrun.
  - Otherwise load_error=1 and palette_valid=0.
  - A partial byte group (byte_cnt!=0) at dl_en fall sets load_error.
- Simultaneous events:
  - dl_wr in the same cycle as dl_en fall: the byte is accepted.
  - dl_en re-rise during DRAIN: the pending entry still commits, then the new load starts. The rise is latched.
- Reset mid-load: immediate return to IDLE. No further writes. RAM contents are left as-is, and palette_valid=0.

Optional Feature:
- Macro: PAL_LOAD_BLANK_GATE_EN.
  - Defined: write window = blank. Commits wait for HBlank/VBlank; dl_wait can stay high for up to one active line (~256 pixels).
  - Undefined: write window = 1. Commits occur the cycle after capture, regardless of raster, accepting single-pixel glitches; dl_wait is then high for at most one cycle.

Decomposition:
- Package nes_pal_pkg:
  - typedef rgb24_t (struct R,G,B 8 bits).
  - enum pal_load_state_t {IDLE,RECV,DRAIN,DONE}.
  - localparams PAL_ENTRIES=64, PAL_BYTES_PER_ENTRY=3.
- Sub-module pal_byte_packer: byte_cnt plus R/G shift registers; outputs rgb24_t and an entry_done pulse. The FSM, hold register and commit logic stay in pal_load_ctrl.

Test Plan:
- Full load, blank=1: 192 bytes with entry k = {k,k+1,k+2} → 64 load_color pulses, index 0..63, entry 5 data 0x050607; after dl_en fall, palette_valid=1, load_error=0.
- Gated (macro on): blank=0, send 3 bytes 0xFF,0x00,0x80 → no strobe, dl_wait=0; send 2 more bytes then hold the third → dl_wait=1; raise blank → one strobe, data 0xFF0080, idx 0, then dl_wait=0.
- Short load: 150 bytes then dl_en fall → 50 strobes, palette_valid=0, load_error=1.
- Overrun: strobe dl_wr while dl_wait=1 → byte dropped, load_error=1 at DONE, palette_valid=0.
- Long file: 1536 bytes → exactly 64 strobes, last index 63, palette_valid=1.
- Reset at byte 100 → all outputs 0, no further strobes; a fresh 192-byte load afterwards succeeds.
